// File: rtl/toycpu_pkg.sv
// rtl/toycpu_pkg.sv - shared types and constants for the toycpu memory responder
package toycpu_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    W_HI,
    W_LO,
    RUN
  } ld_state_t;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;
  localparam logic [7:0]  IO_OFF_OUT      = 8'd0;
  localparam logic [7:0]  IO_OFF_CYC      = 8'd1;

endpackage

// File: rtl/toycpu_ram.sv
// rtl/toycpu_ram.sv - single write port, asynchronous read, 16-bit wide RAM
module toycpu_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/toycpu_mem_responder.sv
// rtl/toycpu_mem_responder.sv - program loader, instruction/data memories and I/O registers beside processor_top
module toycpu_mem_responder
  import toycpu_pkg::*;
#(
  parameter int          IMEM_AW = 8,
  parameter int          DMEM_AW = 8,
  parameter logic [15:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_err,
  output logic        cpu_rst,
  input  logic [15:0] instr_addr,
  output logic [15:0] instr_data,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        mem_we,
  output logic [15:0] mem_rdata,
  output logic [15:0] out_reg
);

  ld_state_t        state;
  logic [7:0]       hi_byte;
  logic [15:0]      remaining;
  logic [IMEM_AW:0] ptr;
  logic [15:0]      cycle_cnt;

  logic        ld_fire;
  logic        ptr_full;
  logic        imem_we;
  logic [15:0] imem_rdata;
  logic [15:0] dmem_rdata;
  logic        is_io;
  logic        is_dmem;
  logic        cpu_we;
  logic        dmem_we;
  logic        out_we;

  assign ld_ready = (state != RUN);
  assign ld_fire  = ld_valid && ld_ready;
  // The extra pointer bit marks "imem full"; once set, further words are dropped.
  assign ptr_full = ptr[IMEM_AW];
  assign imem_we  = ld_fire && (state == W_LO) && !ptr_full;

  toycpu_ram #(.AW(IMEM_AW)) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (ptr[IMEM_AW-1:0]),
    .wdata ({hi_byte, ld_data}),
    .raddr (instr_addr[IMEM_AW-1:0]),
    .rdata (imem_rdata)
  );

  assign instr_data = ((instr_addr >> IMEM_AW) == 16'd0) ? imem_rdata : 16'h0000;

  assign is_io   = (mem_addr[15:8] == IO_BASE[15:8]);
  assign is_dmem = !is_io && ((mem_addr >> DMEM_AW) == 16'd0);
  // cpu_rst is low only in RUN, so this also blocks stores during loading.
  assign cpu_we  = mem_we && !cpu_rst;
  assign dmem_we = cpu_we && is_dmem;
  assign out_we  = cpu_we && is_io && (mem_addr[7:0] == IO_OFF_OUT);

  toycpu_ram #(.AW(DMEM_AW)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (mem_addr[DMEM_AW-1:0]),
    .wdata (mem_wdata),
    .raddr (mem_addr[DMEM_AW-1:0]),
    .rdata (dmem_rdata)
  );

  always_comb begin
    mem_rdata = 16'h0000;
    if (is_io) begin
      if (mem_addr[7:0] == IO_OFF_OUT) begin
        mem_rdata = out_reg;
      end else if (mem_addr[7:0] == IO_OFF_CYC) begin
        mem_rdata = cycle_cnt;
      end
    end else if (is_dmem) begin
      mem_rdata = dmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HDR_HI;
      hi_byte   <= 8'd0;
      remaining <= 16'd0;
      ptr       <= '0;
      ld_err    <= 1'b0;
      cpu_rst   <= 1'b1;
      out_reg   <= 16'd0;
      cycle_cnt <= 16'd0;
    end else begin
      cpu_rst   <= (state != RUN);
      cycle_cnt <= (state == RUN) ? cycle_cnt + 16'd1 : 16'd0;
      if (out_we) begin
        out_reg <= mem_wdata;
      end
      if (ld_fire) begin
        case (state)
          HDR_HI: begin
            hi_byte <= ld_data;
            state   <= HDR_LO;
          end
          HDR_LO: begin
            remaining <= {hi_byte, ld_data};
            state     <= ({hi_byte, ld_data} == 16'd0) ? RUN : W_HI;
          end
          W_HI: begin
            hi_byte <= ld_data;
            state   <= W_LO;
          end
          W_LO: begin
            if (!ptr_full) begin
              ptr <= ptr + {{IMEM_AW{1'b0}}, 1'b1};
              if ((ptr[IMEM_AW-1:0] == '1) && (remaining != 16'd1)) begin
                ld_err <= 1'b1;
              end
            end
            remaining <= remaining - 16'd1;
            state     <= (remaining == 16'd1) ? RUN : W_HI;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_toycpu_mem_responder.sv
// tb/tb_toycpu_mem_responder.sv - randomized model-checked bench for toycpu_mem_responder
module tb_toycpu_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic [15:0] instr_addr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;

  logic        ld_ready_a, ld_err_a, cpu_rst_a;
  logic [15:0] instr_data_a, mem_rdata_a, out_reg_a;
  logic        ld_ready_b, ld_err_b, cpu_rst_b;
  logic [15:0] instr_data_b, mem_rdata_b, out_reg_b;

  toycpu_mem_responder #(.IMEM_AW(8), .DMEM_AW(8), .IO_BASE(16'hFF00)) dut_a (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready_a), .ld_err(ld_err_a), .cpu_rst(cpu_rst_a),
    .instr_addr(instr_addr), .instr_data(instr_data_a),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata_a), .out_reg(out_reg_a)
  );

  toycpu_mem_responder #(.IMEM_AW(2), .DMEM_AW(8), .IO_BASE(16'hFF00)) dut_b (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready_b), .ld_err(ld_err_b), .cpu_rst(cpu_rst_b),
    .instr_addr(instr_addr), .instr_data(instr_data_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata_b), .out_reg(out_reg_b)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_on = 0;
  bit hit = 0;

  // Reference model: one entry per DUT (0: 256-word imem, 1: 4-word imem)
  int          depth [2] = '{256, 4};
  int          m_bytes [2];
  logic [15:0] m_n [2];
  logic [7:0]  m_hi [2];
  bit          m_run [2];
  int          m_k [2];
  bit          m_err [2];
  logic [15:0] m_out [2];
  logic [15:0] m_imem [2][256];
  bit          m_iv [2][256];
  logic [15:0] m_dmem [2][256];
  bit          m_dv [2][256];

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_step(int u);
    int i, j;
    if (!rst) begin
      m_bytes[u] = 0; m_run[u] = 0; m_k[u] = 0; m_err[u] = 0; m_out[u] = 16'h0;
    end else if (m_run[u]) begin
      if (mem_we && m_k[u] >= 1) begin
        if (mem_addr[15:8] == 8'hFF) begin
          if (mem_addr[7:0] == 8'h00) m_out[u] = mem_wdata;
        end else if (mem_addr < 16'd256) begin
          m_dmem[u][mem_addr[7:0]] = mem_wdata;
          m_dv[u][mem_addr[7:0]] = 1;
        end
      end
      m_k[u]++;
    end else if (ld_valid) begin
      i = m_bytes[u];
      if (i == 0) m_n[u][15:8] = ld_data;
      else if (i == 1) begin
        m_n[u][7:0] = ld_data;
        if (m_n[u] == 16'd0) m_run[u] = 1;
      end else begin
        j = (i - 2) / 2;
        if (i % 2 == 0) m_hi[u] = ld_data;
        else begin
          if (j < depth[u]) begin
            m_imem[u][j] = {m_hi[u], ld_data};
            m_iv[u][j] = 1;
          end
          if (j == depth[u] - 1 && int'(m_n[u]) > depth[u]) m_err[u] = 1;
          if (j + 1 == int'(m_n[u])) m_run[u] = 1;
        end
      end
      m_bytes[u] = i + 1;
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) model_step(u);
  end

  task automatic compare_unit(int u);
    logic        rdy, crst, err;
    logic [15:0] id, rd, outr, e;
    bit          known;
    if (u == 0) begin
      rdy = ld_ready_a; crst = cpu_rst_a; err = ld_err_a; id = instr_data_a; rd = mem_rdata_a; outr = out_reg_a;
    end else begin
      rdy = ld_ready_b; crst = cpu_rst_b; err = ld_err_b; id = instr_data_b; rd = mem_rdata_b; outr = out_reg_b;
    end
    chk($sformatf("u%0d ld_ready", u), {15'd0, rdy}, {15'd0, !m_run[u]});
    chk($sformatf("u%0d cpu_rst", u), {15'd0, crst}, {15'd0, !(m_run[u] && m_k[u] >= 1)});
    chk($sformatf("u%0d ld_err", u), {15'd0, err}, {15'd0, m_err[u]});
    chk($sformatf("u%0d out_reg", u), outr, m_out[u]);
    if (int'(instr_addr) >= depth[u]) begin
      chk($sformatf("u%0d instr_data oor %h", u, instr_addr), id, 16'h0000);
    end else if (m_iv[u][instr_addr[7:0]]) begin
      chk($sformatf("u%0d instr_data %h", u, instr_addr), id, m_imem[u][instr_addr[7:0]]);
    end
    known = 1;
    e = 16'h0000;
    if (mem_addr[15:8] == 8'hFF) begin
      if (mem_addr[7:0] == 8'h00) e = m_out[u];
      else if (mem_addr[7:0] == 8'h01) e = 16'(m_k[u]);
    end else if (mem_addr < 16'd256) begin
      known = m_dv[u][mem_addr[7:0]];
      e = m_dmem[u][mem_addr[7:0]];
    end
    if (known) chk($sformatf("u%0d mem_rdata %h", u, mem_addr), rd, e);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      compare_unit(0);
      compare_unit(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_cpu();
    case ($urandom_range(0, 5))
      0, 1: mem_addr = 16'($urandom_range(0, 31));
      2: mem_addr = 16'hFF00;
      3: mem_addr = 16'hFF01;
      4: mem_addr = 16'($urandom);
      default: mem_addr = 16'h4000 | 16'($urandom_range(0, 255));
    endcase
    mem_we = ($urandom_range(0, 2) == 0);
    mem_wdata = 16'($urandom);
    case ($urandom_range(0, 2))
      0: instr_addr = 16'($urandom_range(0, 7));
      1: instr_addr = 16'h0100;
      default: instr_addr = 16'($urandom);
    endcase
  endtask

  // noise: 0 none, 1 random cpu inputs, 2 stores to 0x0010
  task automatic send(logic [7:0] b, bit gaps, int noise);
    while (gaps && $urandom_range(0, 2) == 0) begin
      ld_valid = 0;
      ld_data = 8'($urandom);
      if (noise == 1) rand_cpu();
      tick();
    end
    if (noise == 1) rand_cpu();
    if (noise == 2) begin
      mem_we = 1; mem_addr = 16'h0010; mem_wdata = 16'($urandom);
    end
    ld_valid = 1;
    ld_data = b;
    tick();
    ld_valid = 0;
  endtask

  task automatic send_word(logic [15:0] w, bit gaps, int noise);
    send(w[15:8], gaps, noise);
    send(w[7:0], gaps, noise);
  endtask

  task automatic do_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic store(logic [15:0] a, logic [15:0] d);
    mem_addr = a; mem_wdata = d; mem_we = 1;
    tick();
    mem_we = 0;
  endtask

  initial begin
    logic [15:0] n;
    rst = 0; ld_valid = 0; ld_data = 0; instr_addr = 0; mem_addr = 0; mem_wdata = 0; mem_we = 0;
    repeat (3) tick();
    rst = 1;
    chk_on = 1;
    mem_addr = 16'hFF01;
    @(negedge clk);
    chk("reset ld_ready", {15'd0, ld_ready_a}, 16'd1);
    chk("reset cpu_rst", {15'd0, cpu_rst_a}, 16'd1);
    chk("reset ld_err", {15'd0, ld_err_a}, 16'd0);
    chk("reset out_reg", out_reg_a, 16'h0000);
    chk("reset cycle", mem_rdata_a, 16'h0000);
    tick();

    send_word(16'h0002, 0, 0);
    send_word(16'h1234, 0, 0);
    send_word(16'hABCD, 0, 0);
    mem_addr = 16'hFF01;
    @(negedge clk);
    chk("run entry ld_ready", {15'd0, ld_ready_a}, 16'd0);
    chk("run entry cpu_rst", {15'd0, cpu_rst_a}, 16'd1);
    chk("run entry cycle", mem_rdata_a, 16'h0000);
    tick();
    @(negedge clk);
    chk("release cpu_rst", {15'd0, cpu_rst_a}, 16'd0);
    chk("second run cycle", mem_rdata_a, 16'h0001);
    #1 instr_addr = 16'h0001;
    #1 chk("fetch 1", instr_data_a, 16'hABCD);
    instr_addr = 16'h0000;
    #1 chk("fetch 0", instr_data_a, 16'h1234);
    instr_addr = 16'h0100;
    #1 chk("fetch 0100", instr_data_a, 16'h0000);
    tick();

    store(16'h0010, 16'h5A5A);
    mem_addr = 16'h0010;
    @(negedge clk);
    chk("dmem store 0010", mem_rdata_a, 16'h5A5A);
    tick();
    store(16'hFF00, 16'h1357);
    @(negedge clk);
    chk("out_reg store", out_reg_a, 16'h1357);
    tick();
    store(16'hFF01, 16'h0000);
    @(negedge clk);
    chk("cycle after ff01 store", mem_rdata_a, 16'(m_k[0]));
    tick();
    store(16'h4000, 16'hBEEF);
    mem_addr = 16'h4000;
    @(negedge clk);
    chk("unmapped read", mem_rdata_a, 16'h0000);
    tick();

    repeat (300) begin
      rand_cpu();
      ld_valid = $urandom_range(0, 1);
      ld_data = 8'($urandom);
      tick();
    end
    ld_valid = 0;

    store(16'h0010, 16'hC0DE);
    do_reset();
    send(8'h00, 0, 2);
    send(8'h05, 0, 2);
    send(8'h11, 0, 2);
    do_reset();
    mem_we = 0;
    @(negedge clk);
    chk("midload rst ld_ready", {15'd0, ld_ready_a}, 16'd1);
    chk("midload rst cpu_rst", {15'd0, cpu_rst_a}, 16'd1);
    tick();
    send_word(16'h0001, 1, 2);
    send_word(16'hBEEF, 1, 2);
    mem_we = 0;
    tick();
    mem_addr = 16'h0010;
    instr_addr = 16'h0000;
    @(negedge clk);
    chk("reload imem0", instr_data_a, 16'hBEEF);
    chk("dmem untouched by load", mem_rdata_a, 16'hC0DE);
    tick();

    do_reset();
    send(8'h00, 0, 0);
    send(8'h00, 0, 0);
    instr_addr = 16'h0000;
    @(negedge clk);
    chk("hdr0 run", {15'd0, ld_ready_a}, 16'd0);
    chk("hdr0 imem kept", instr_data_a, 16'hBEEF);
    tick();
    @(negedge clk);
    chk("hdr0 cpu_rst", {15'd0, cpu_rst_a}, 16'd0);
    tick();

    do_reset();
    send_word(16'h0005, 1, 0);
    send_word(16'h1111, 1, 0);
    send_word(16'h2222, 1, 0);
    send_word(16'h3333, 1, 0);
    send_word(16'h4444, 1, 0);
    send_word(16'h5555, 1, 0);
    instr_addr = 16'h0003;
    @(negedge clk);
    chk("ovf ld_ready_b", {15'd0, ld_ready_b}, 16'd0);
    chk("ovf ld_err_b", {15'd0, ld_err_b}, 16'd1);
    chk("ovf ld_err_a", {15'd0, ld_err_a}, 16'd0);
    chk("ovf imem_b 3", instr_data_b, 16'h4444);
    #1 instr_addr = 16'h0004;
    #1 chk("ovf imem_b 4", instr_data_b, 16'h0000);
    chk("ovf imem_a 4", instr_data_a, 16'h5555);
    tick();

    repeat (3) begin
      do_reset();
      n = 16'($urandom_range(0, 6));
      send_word(n, 1, 1);
      for (int w = 0; w < int'(n); w++) send_word(16'($urandom), 1, 1);
      repeat (100) begin
        rand_cpu();
        ld_valid = $urandom_range(0, 1);
        ld_data = 8'($urandom);
        tick();
      end
      ld_valid = 0;
    end

    mem_we = 0;
    mem_addr = 16'hFF01;
    for (int c = 0; c < 70000 && !hit; c++) begin
      @(negedge clk);
      if (mem_rdata_a == 16'hFFFF) hit = 1;
      else tick();
    end
    if (hit) begin
      tick();
      @(negedge clk);
      chk("cycle wrap", mem_rdata_a, 16'h0000);
    end else begin
      chk("cycle reach ffff timeout", mem_rdata_a, 16'hFFFF);
    end
    tick();

    chk_on = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
